// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctrl
// Purpose  : Fetch PC sequencer with redirect, timed stall and pending-jump
//            replay; drives flush/hold to the front-end pipeline registers.
// Revision : 1.0
// ============================================================================
module pc_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_o,
  output logic        hold_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] c_hold_load = 4'(HOLD_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [3:0]  r_cnt;
  logic        r_pend_vld;
  logic [31:0] r_pend_addr;
  logic        r_misalign;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_valid_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_pend_vld_nxt;
  logic [31:0] w_pend_addr_nxt;
  logic        w_misalign_nxt;
  logic        w_flush;
  logic        w_hold;

  // A jump arriving in the exit cycle itself is the newest request, so it wins.
  logic        w_take;
  logic [31:0] w_tgt;
  assign w_take = jump_en_i | r_pend_vld;
  assign w_tgt  = jump_en_i ? jump_addr_i : r_pend_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_valid     <= 1'b0;
      r_cnt       <= 4'd0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= 32'd0;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_valid     <= w_valid_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_misalign  <= w_misalign_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_valid_nxt     = r_valid;
    w_cnt_nxt       = r_cnt;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_addr_nxt = r_pend_addr;
    w_misalign_nxt  = 1'b0;
    w_flush         = 1'b0;
    w_hold          = 1'b0;

    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
        w_pc_nxt    = RESET_PC;
        w_valid_nxt = 1'b1;
      end

      S_RUN: begin
        if (jump_en_i) begin
          w_flush        = 1'b1;
          w_pc_nxt       = {jump_addr_i[31:2], 2'b00};
          w_misalign_nxt = |jump_addr_i[1:0];
        end else if (hold_flag_i) begin
          w_hold = 1'b1;
        end else begin
          w_pc_nxt = r_pc + 32'd4;
        end
        if (hold_flag_i) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_hold_load;
        end
      end

      S_HOLD: begin
        if ((r_cnt == 4'd0) && !hold_flag_i) begin
          w_state_nxt    = S_RUN;
          w_pend_vld_nxt = 1'b0;
          if (w_take) begin
            w_flush        = 1'b1;
            w_pc_nxt       = {w_tgt[31:2], 2'b00};
            w_misalign_nxt = |w_tgt[1:0];
          end else begin
            w_hold   = 1'b1;
            w_pc_nxt = r_pc + 32'd4;
          end
        end else begin
          w_hold = 1'b1;
          if (r_cnt != 4'd0) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
          if (jump_en_i) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_addr_nxt = jump_addr_i;
          end
        end
      end

      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // Gate with rst so the strobes are quiet while reset is held, whatever the inputs.
  assign flush_o    = w_flush & rst;
  assign hold_o     = w_hold & ~w_flush & rst;
  assign pc_o       = r_pc;
  assign pc_valid_o = r_valid;
  assign misalign_o = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// Self-checking bench for pc_ctrl: directed literal scenarios followed by
// randomized traffic compared every cycle against a behavioural model.
module tb_pc_ctrl;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          HOLD_CYCLES = 3;

  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        jump_en_i   = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        hold_flag_i = 1'b0;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic        hold_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  pc_ctrl #(
    .RESET_PC   (RESET_PC),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .jump_en_i  (jump_en_i),
    .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i),
    .pc_o       (pc_o),
    .pc_valid_o (pc_valid_o),
    .flush_o    (flush_o),
    .hold_o     (hold_o),
    .misalign_o (misalign_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=boot, 1=run, 2=hold; m_left = hold cycles still owed.
  int          m_mode      = 0;
  logic [31:0] m_pc        = RESET_PC;
  bit          m_mis       = 1'b0;
  int          m_left      = 0;
  bit          m_pend      = 1'b0;
  logic [31:0] m_pend_addr = 32'd0;

  function automatic bit m_exiting();
    return (m_mode == 2) && (m_left == 0) && !hold_flag_i;
  endfunction

  function automatic bit m_flush();
    if (!rst) return 1'b0;
    if (m_mode == 1) return jump_en_i;
    if (m_exiting()) return m_pend || jump_en_i;
    return 1'b0;
  endfunction

  function automatic bit m_hold();
    if (!rst || m_flush()) return 1'b0;
    if (m_mode == 1) return hold_flag_i;
    return m_mode == 2;
  endfunction

  always @(posedge clk or negedge rst) begin : model_upd
    int          n_mode;
    int          n_left;
    logic [31:0] n_pc;
    logic [31:0] target;
    bit          n_pend;
    logic [31:0] n_pend_addr;
    bit          redirect;
    if (!rst) begin
      m_mode <= 0;
      m_pc   <= RESET_PC;
      m_mis  <= 1'b0;
      m_left <= 0;
      m_pend <= 1'b0;
    end else begin
      n_mode      = m_mode;
      n_left      = m_left;
      n_pc        = m_pc;
      n_pend      = m_pend;
      n_pend_addr = m_pend_addr;
      redirect    = 1'b0;
      target      = jump_addr_i;
      if (m_mode == 0) begin
        n_mode = 1;
      end else if (m_mode == 1) begin
        redirect = jump_en_i;
        if (hold_flag_i) begin
          n_mode = 2;
          n_left = HOLD_CYCLES - 1;
        end else if (!jump_en_i) begin
          n_pc = m_pc + 32'd4;
        end
      end else if (m_exiting()) begin
        n_mode = 1;
        n_pend = 1'b0;
        if (jump_en_i || m_pend) begin
          redirect = 1'b1;
          if (!jump_en_i) target = m_pend_addr;
        end else begin
          n_pc = m_pc + 32'd4;
        end
      end else begin
        if (m_left > 0) n_left = m_left - 1;
        if (jump_en_i) begin
          n_pend      = 1'b1;
          n_pend_addr = jump_addr_i;
        end
      end
      if (redirect) n_pc = target - (target % 32'd4);
      m_mode      <= n_mode;
      m_left      <= n_left;
      m_pc        <= n_pc;
      m_pend      <= n_pend;
      m_pend_addr <= n_pend_addr;
      m_mis       <= redirect && ((target % 32'd4) != 32'd0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_o", pc_o, m_pc);
      check("pc_valid_o", {31'b0, pc_valid_o}, (m_mode != 0) ? 32'd1 : 32'd0);
      check("flush_o", {31'b0, flush_o}, {31'b0, m_flush()});
      check("hold_o", {31'b0, hold_o}, {31'b0, m_hold()});
      check("misalign_o", {31'b0, misalign_o}, {31'b0, m_mis});
      check("flush_and_hold", {31'b0, flush_o & hold_o}, 32'd0);
    end
  end

  task automatic cyc(input bit je, input logic [31:0] ja, input bit hf);
    @(posedge clk);
    #1;
    jump_en_i   = je;
    jump_addr_i = ja;
    hold_flag_i = hf;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("boot_valid", {31'b0, pc_valid_o}, 32'd0);
    check("boot_pc", pc_o, 32'h0);

    cyc(0, 32'd0, 0); check("run_pc0", pc_o, 32'h0); check("run_valid", {31'b0, pc_valid_o}, 32'd1);
    cyc(0, 32'd0, 0); check("run_pc4", pc_o, 32'h4);
    cyc(0, 32'd0, 0); check("run_pc8", pc_o, 32'h8);
    cyc(0, 32'd0, 0); check("run_pcC", pc_o, 32'hC);

    // misaligned jump
    cyc(1, 32'h0000_0102, 0); check("jmp_pc", pc_o, 32'h10); check("jmp_flush", {31'b0, flush_o}, 32'd1);
    cyc(0, 32'd0, 0); check("jmp_tgt", pc_o, 32'h100); check("jmp_mis", {31'b0, misalign_o}, 32'd1);
    cyc(0, 32'd0, 0); check("jmp_next", pc_o, 32'h104); check("jmp_mis_clr", {31'b0, misalign_o}, 32'd0);

    // one-cycle hold pulse at 0x20
    cyc(1, 32'h20, 0);
    cyc(0, 32'd0, 1); check("hold_req_pc", pc_o, 32'h20); check("hold_req", {31'b0, hold_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 32'd0, 0); check("hold_pc", pc_o, 32'h20); check("hold_o", {31'b0, hold_o}, 32'd1);
    end
    cyc(0, 32'd0, 0); check("hold_exit_pc", pc_o, 32'h24); check("hold_exit_o", {31'b0, hold_o}, 32'd0);

    // jump pended during hold
    cyc(0, 32'd0, 1); check("pend_req_pc", pc_o, 32'h28);
    cyc(1, 32'h200, 0); check("pend_noflush", {31'b0, flush_o}, 32'd0);
    cyc(0, 32'd0, 0); check("pend_noflush2", {31'b0, flush_o}, 32'd0);
    cyc(0, 32'd0, 0); check("pend_exit_flush", {31'b0, flush_o}, 32'd1); check("pend_exit_hold", {31'b0, hold_o}, 32'd0);
    cyc(0, 32'd0, 0); check("pend_pc", pc_o, 32'h200);

    // jump and hold in the same cycle
    cyc(1, 32'h40, 1); check("jh_flush", {31'b0, flush_o}, 32'd1); check("jh_hold", {31'b0, hold_o}, 32'd0);
    for (int k = 0; k < HOLD_CYCLES; k++) begin
      cyc(0, 32'd0, 0); check("jh_frozen", pc_o, 32'h40);
    end
    cyc(0, 32'd0, 0); check("jh_resume", pc_o, 32'h44);

    // 32-bit wrap, then async reset mid-hold with a pending jump
    cyc(1, 32'hFFFF_FFFC, 0);
    cyc(0, 32'd0, 0); check("wrap_top", pc_o, 32'hFFFF_FFFC);
    cyc(0, 32'd0, 0); check("wrap_zero", pc_o, 32'h0);
    cyc(0, 32'd0, 1);
    cyc(1, 32'h300, 0);
    hold_flag_i = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("arst_pc", pc_o, RESET_PC);
    check("arst_valid", {31'b0, pc_valid_o}, 32'd0);
    check("arst_flush", {31'b0, flush_o}, 32'd0);
    check("arst_hold", {31'b0, hold_o}, 32'd0);
    check("arst_mis", {31'b0, misalign_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; jump_en_i = 1'b0; hold_flag_i = 1'b0;
    @(negedge clk); check("rboot_valid", {31'b0, pc_valid_o}, 32'd0);
    cyc(0, 32'd0, 0); check("rboot_pc0", pc_o, 32'h0);
    cyc(0, 32'd0, 0); check("rboot_pc4", pc_o, 32'h4); check("rboot_nohold", {31'b0, hold_o}, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (!rst && ($urandom_range(0, 1) == 1)) rst = 1'b1;
      jump_en_i   = ($urandom_range(0, 99) < 15);
      jump_addr_i = $urandom;
      hold_flag_i = ($urandom_range(0, 99) < 20);
      if (rst && ($urandom_range(0, 299) == 0)) begin
        #2 rst = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    rst = 1'b1; jump_en_i = 1'b0; hold_flag_i = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
